// File: rtl/bitbang_tx.sv
// bitbang_tx: serializes 32-bit configuration words onto the fabric's
// s_clk/s_data bitbang port, MSB first. Each bit-period has four phases of
// CLK_DIV cycles: P0 sets up the data bit, P1 raises s_clk, P2 drives the
// control bit, and P3 drops s_clk. A one-entry holding buffer lets words
// stream with no gap between them.
module bitbang_tx #(
  parameter int          CLK_DIV   = 4,
  parameter logic [15:0] CTRL_WORD = 16'hFAB0
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] WriteData,
  input  logic        WriteValid,
  output logic        WriteReady,
  input  logic        Abort,
  output logic        s_clk,
  output logic        s_data,
  output logic        Busy,
  output logic        WordDone
);

  localparam int               DIV_W      = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PENULT = DIV_W'(CLK_DIV - 2);
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2,
    P3 = 2'd3
  } phase_t;

  state_t           state_r,     stateNext_s;
  phase_t           phase_r,     phaseNext_s;
  logic [DIV_W-1:0] divCnt_r,    divNext_s;
  logic [4:0]       bitCnt_r,    bitNext_s;
  logic [31:0]      shiftReg_r,  shiftNext_s;
  logic [31:0]      holdBuf_r,   holdNext_s;
  logic             hbFull_r,    hbFullNext_s;
  logic             sClk_r,      sClkNext_s;
  logic             sData_r,     sDataNext_s;
  logic             wordDone_r,  wordDoneNext_s;
  logic             busy_r,      busyNext_s;
  logic             writeReady_r, writeReadyNext_s;
  logic             accept_s;
  logic             loadSr_s;

  // Control bit for bit b: zero for the first 16 bits, then CTRL_WORD MSB
  // first. For b = 16+k the CTRL_WORD index 15-k is simply ~k in 4 bits.
  function automatic logic ctrlBit(input logic [4:0] b);
    logic [3:0] idx;
    idx = ~b[3:0];
    if (b[4]) begin
      return CTRL_WORD[idx];
    end else begin
      return 1'b0;
    end
  endfunction

  assign WriteReady = writeReady_r;
  assign s_clk      = sClk_r;
  assign s_data     = sData_r;
  assign Busy       = busy_r;
  assign WordDone   = wordDone_r;

  // Next-state and next-output logic for the serializer FSM and holding buffer.
  always_comb begin
    accept_s       = WriteValid & writeReady_r;
    loadSr_s       = 1'b0;
    stateNext_s    = state_r;
    phaseNext_s    = phase_r;
    divNext_s      = divCnt_r;
    bitNext_s      = bitCnt_r;
    shiftNext_s    = shiftReg_r;
    holdNext_s     = accept_s ? WriteData : holdBuf_r;
    hbFullNext_s   = hbFull_r;
    sClkNext_s     = sClk_r;
    sDataNext_s    = sData_r;
    wordDoneNext_s = 1'b0;

    case (state_r)
      IDLE: begin
        if (hbFull_r) begin
          loadSr_s = 1'b1;
        end else begin
          sClkNext_s  = 1'b0;
          sDataNext_s = 1'b0;
        end
      end
      SHIFT: begin
        // WordDone is registered, so it is armed one cycle ahead of the
        // final P3 cycle (CLK_DIV >= 2 guarantees that cycle exists).
        wordDoneNext_s = (phase_r == P3) && (divCnt_r == DIV_PENULT) && (bitCnt_r == 5'd31);
        if (divCnt_r == DIV_LAST) begin
          divNext_s = '0;
          case (phase_r)
            P0: begin
              phaseNext_s = P1;
              sClkNext_s  = 1'b1;
            end
            P1: begin
              phaseNext_s = P2;
              sDataNext_s = ctrlBit(bitCnt_r);
            end
            P2: begin
              phaseNext_s = P3;
              sClkNext_s  = 1'b0;
            end
            P3: begin
              if (bitCnt_r == 5'd31) begin
                if (hbFull_r) begin
                  loadSr_s = 1'b1;
                end else begin
                  stateNext_s = IDLE;
                  phaseNext_s = P0;
                  bitNext_s   = 5'd0;
                  sDataNext_s = 1'b0;
                end
              end else begin
                // Rotate rather than shift so the next data bit is always
                // found at position 30 before the move, i.e. 31 after it.
                phaseNext_s = P0;
                bitNext_s   = bitCnt_r + 5'd1;
                shiftNext_s = {shiftReg_r[30:0], shiftReg_r[31]};
                sDataNext_s = shiftReg_r[30];
              end
            end
            default: begin
              stateNext_s = IDLE;
              phaseNext_s = P0;
              sClkNext_s  = 1'b0;
              sDataNext_s = 1'b0;
            end
          endcase
        end else begin
          divNext_s = divCnt_r + DIV_ONE;
        end
      end
      default: begin
        stateNext_s = IDLE;
        phaseNext_s = P0;
        sClkNext_s  = 1'b0;
        sDataNext_s = 1'b0;
      end
    endcase

    // Moving HB into SR frees the buffer; a same-cycle accept refills it.
    if (loadSr_s) begin
      stateNext_s  = SHIFT;
      phaseNext_s  = P0;
      divNext_s    = '0;
      bitNext_s    = 5'd0;
      shiftNext_s  = holdBuf_r;
      sDataNext_s  = holdBuf_r[31];
      sClkNext_s   = 1'b0;
      hbFullNext_s = accept_s;
    end else begin
      hbFullNext_s = hbFull_r | accept_s;
    end

    busyNext_s       = (stateNext_s != IDLE) | hbFullNext_s;
    writeReadyNext_s = ~hbFullNext_s;
  end

  // State and output registers; Abort clears everything exactly like reset.
  always_ff @(posedge CLK) begin
    if (reset || Abort) begin
      state_r      <= IDLE;
      phase_r      <= P0;
      divCnt_r     <= '0;
      bitCnt_r     <= 5'd0;
      shiftReg_r   <= 32'd0;
      holdBuf_r    <= 32'd0;
      hbFull_r     <= 1'b0;
      sClk_r       <= 1'b0;
      sData_r      <= 1'b0;
      wordDone_r   <= 1'b0;
      busy_r       <= 1'b0;
      writeReady_r <= 1'b1;
    end else begin
      state_r      <= stateNext_s;
      phase_r      <= phaseNext_s;
      divCnt_r     <= divNext_s;
      bitCnt_r     <= bitNext_s;
      shiftReg_r   <= shiftNext_s;
      holdBuf_r    <= holdNext_s;
      hbFull_r     <= hbFullNext_s;
      sClk_r       <= sClkNext_s;
      sData_r      <= sDataNext_s;
      wordDone_r   <= wordDoneNext_s;
      busy_r       <= busyNext_s;
      writeReady_r <= writeReadyNext_s;
    end
  end

endmodule

// File: tb/tb_bitbang_tx.sv
// Testbench for bitbang_tx: a receiver model reconstructs data words from
// s_data at s_clk rising edges and control words at falling edges, and the
// results are compared against the words the bench handed over.
module tb_bitbang_tx;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        reset, Abort, WriteValid, WriteValid4;
  logic [31:0] WriteData, WriteData4;
  logic        WriteReady, s_clk, s_data, Busy, WordDone;
  logic        WriteReady4, sClk4, sData4, Busy4, WordDone4;

  bitbang_tx #(.CLK_DIV(2), .CTRL_WORD(16'hFAB0)) dut (
    .CLK(CLK), .reset(reset), .WriteData(WriteData), .WriteValid(WriteValid),
    .WriteReady(WriteReady), .Abort(Abort), .s_clk(s_clk), .s_data(s_data),
    .Busy(Busy), .WordDone(WordDone)
  );

  bitbang_tx #(.CLK_DIV(4), .CTRL_WORD(16'hFAB0)) dut4 (
    .CLK(CLK), .reset(reset), .WriteData(WriteData4), .WriteValid(WriteValid4),
    .WriteReady(WriteReady4), .Abort(1'b0), .s_clk(sClk4), .s_data(sData4),
    .Busy(Busy4), .WordDone(WordDone4)
  );

  localparam logic [31:0] CTRL_EXP = 32'h0000FAB0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Cycle index: value seen between edges is the number of rising edges so far.
  always @(posedge CLK) cyc <= cyc + 1;

  // Handshake observer: records the cycle index following each accepting edge.
  int acceptT[$];
  always @(posedge CLK) begin
    if (reset === 1'b0 && Abort === 1'b0 && WriteValid === 1'b1 && WriteReady === 1'b1)
      acceptT.push_back(cyc + 1);
  end

  // Receiver model for the CLK_DIV=2 instance.
  logic        prevClk = 1'b0;
  logic [31:0] dAcc = 32'd0, cAcc = 32'd0;
  int          dN = 0, cN = 0, riseCnt = 0, fallCnt = 0;
  logic [31:0] gotWords[$], gotCtrl[$];
  int          riseT[$], doneT[$];
  always @(negedge CLK) begin
    if (s_clk === 1'b1 && prevClk === 1'b0) begin
      dAcc = {dAcc[30:0], s_data};
      dN++; riseCnt++;
      riseT.push_back(cyc);
      if (dN == 32) begin gotWords.push_back(dAcc); dN = 0; end
    end
    if (s_clk === 1'b0 && prevClk === 1'b1) begin
      cAcc = {cAcc[30:0], s_data};
      cN++; fallCnt++;
      if (cN == 32) begin gotCtrl.push_back(cAcc); cN = 0; end
    end
    if (WordDone === 1'b1) doneT.push_back(cyc);
    if (Busy === 1'b0) begin dN = 0; cN = 0; end
    prevClk = s_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want normal completion");
    $fatal(1);
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic flush();
    acceptT.delete(); gotWords.delete(); gotCtrl.delete(); riseT.delete(); doneT.delete();
    riseCnt = 0; fallCnt = 0;
  endtask

  task automatic sendWord(input logic [31:0] w, input bit hold);
    int t = 0;
    WriteData = w;
    WriteValid = 1'b1;
    while (WriteReady !== 1'b1 && t < 1000) begin tick(); t++; end
    checks++;
    if (t >= 1000) begin
      errors++;
      $display("FAIL send_timeout: WriteReady=%b after %0d cycles, want 1", WriteReady, t);
    end
    tick();
    if (!hold) WriteValid = 1'b0;
  endtask

  task automatic waitIdle(input int limit, output int fellAt);
    int t = 0;
    while (Busy !== 1'b0 && t < limit) begin tick(); t++; end
    checks++;
    if (t >= limit) begin
      errors++;
      $display("FAIL idle_timeout: Busy=%b after %0d cycles, want 0", Busy, t);
    end
    fellAt = cyc;
  endtask

  task automatic test_reset();
    reset = 1'b1; Abort = 1'b0; WriteValid = 1'b1; WriteData = $urandom;
    WriteValid4 = 1'b0; WriteData4 = 32'd0;
    repeat (3) begin
      tick();
      checks++;
      if (s_clk !== 1'b0 || s_data !== 1'b0 || Busy !== 1'b0 || WordDone !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: clk=%b data=%b busy=%b done=%b, want 0 0 0 0", s_clk, s_data, Busy, WordDone);
      end
      checks++;
      if (WriteReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", WriteReady); end
    end
    WriteValid = 1'b0;
    reset = 1'b0;
    tick();
    checks++;
    if (WriteReady !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: ready=%b busy=%b, want 1 0", WriteReady, Busy);
    end
    flush();
  endtask

  task automatic test_single();
    int fell, firstShift;
    flush();
    sendWord(32'h12345678, 1'b0);
    firstShift = (acceptT.size() > 0) ? acceptT[0] + 1 : -1000;
    waitIdle(1000, fell);
    checks++;
    if (gotWords.size() != 1 || gotWords[0] !== 32'h12345678) begin
      errors++;
      $display("FAIL single_data: n=%0d word=%h, want 1 word 12345678", gotWords.size(), (gotWords.size() > 0) ? gotWords[0] : 32'hx);
    end
    checks++;
    if (gotCtrl.size() != 1 || gotCtrl[0] !== CTRL_EXP) begin
      errors++;
      $display("FAIL single_ctrl: n=%0d ctrl=%h, want 1 word %h", gotCtrl.size(), (gotCtrl.size() > 0) ? gotCtrl[0] : 32'hx, CTRL_EXP);
    end
    checks++;
    if (riseT.size() != 32) begin errors++; $display("FAIL single_rises: got %0d want 32", riseT.size()); end
    // First data drive one cycle after accept, so the first rise lands after one P0.
    checks++;
    if (riseT.size() == 0 || riseT[0] != firstShift + 2) begin
      errors++;
      $display("FAIL single_latency: first rise at %0d, want %0d", (riseT.size() > 0) ? riseT[0] : -1, firstShift + 2);
    end
    // The word spans 256 cycles; WordDone marks the last of them.
    checks++;
    if (doneT.size() != 1 || doneT[0] != firstShift + 255) begin
      errors++;
      $display("FAIL single_done: n=%0d at %0d, want 1 at %0d", doneT.size(), (doneT.size() > 0) ? doneT[0] : -1, firstShift + 255);
    end
    checks++;
    if (fell != firstShift + 256) begin errors++; $display("FAIL single_busy_fall: at %0d want %0d", fell, firstShift + 256); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[3];
    int fell, bad;
    w[0] = 32'hDEADBEEF; w[1] = 32'h00000001; w[2] = 32'hFFFFFFFF;
    flush();
    sendWord(w[0], 1'b1);
    sendWord(w[1], 1'b1);
    checks++;
    if (WriteReady !== 1'b0) begin errors++; $display("FAIL b2b_ready_drop: got %b want 0", WriteReady); end
    sendWord(w[2], 1'b0);
    waitIdle(3000, fell);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (gotWords.size() <= i || gotWords[i] !== w[i]) begin
        errors++;
        $display("FAIL b2b_word%0d: got %h want %h", i, (gotWords.size() > i) ? gotWords[i] : 32'hx, w[i]);
      end
    end
    checks++;
    if (doneT.size() != 3 || doneT[1] - doneT[0] != 256 || doneT[2] - doneT[1] != 256) begin
      errors++;
      $display("FAIL b2b_done: n=%0d, want 3 pulses 256 apart", doneT.size());
    end
    bad = 0;
    for (int i = 1; i < riseT.size(); i++) if (riseT[i] - riseT[i-1] != 8) bad++;
    checks++;
    if (riseT.size() != 96 || bad != 0) begin
      errors++;
      $display("FAIL b2b_period: rises=%0d irregular=%0d, want 96 and 0", riseT.size(), bad);
    end
  endtask

  task automatic test_random();
    logic [31:0] w[8];
    int gap, fell, badCtrl;
    flush();
    for (int i = 0; i < 8; i++) begin
      w[i] = $urandom;
      gap = $urandom_range(0, 2);
      sendWord(w[i], gap == 0);
      repeat (gap) tick();
    end
    WriteValid = 1'b0;
    waitIdle(4000, fell);
    checks++;
    if (gotWords.size() != 8) begin errors++; $display("FAIL rand_count: got %0d want 8", gotWords.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (gotWords.size() <= i || gotWords[i] !== w[i]) begin
        errors++;
        $display("FAIL rand_word%0d: got %h want %h", i, (gotWords.size() > i) ? gotWords[i] : 32'hx, w[i]);
      end
    end
    badCtrl = 0;
    foreach (gotCtrl[i]) if (gotCtrl[i] !== CTRL_EXP) badCtrl++;
    checks++;
    if (gotCtrl.size() != 8 || badCtrl != 0) begin
      errors++;
      $display("FAIL rand_ctrl: n=%0d bad=%0d, want 8 and 0", gotCtrl.size(), badCtrl);
    end
  endtask

  task automatic test_abort();
    int t = 0;
    flush();
    sendWord(32'hA5A5A5A5, 1'b0);
    sendWord($urandom, 1'b0);
    while (fallCnt < 10 && t < 500) begin tick(); t++; end
    repeat (2) tick();
    checks++;
    if (WriteReady !== 1'b0 || Busy !== 1'b1 || fallCnt != 10) begin
      errors++;
      $display("FAIL abort_setup: ready=%b busy=%b falls=%0d, want 0 1 10", WriteReady, Busy, fallCnt);
    end
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    checks++;
    if (s_clk !== 1'b0 || s_data !== 1'b0 || Busy !== 1'b0 || WriteReady !== 1'b1 || WordDone !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: clk=%b data=%b busy=%b ready=%b done=%b, want 0 0 0 1 0", s_clk, s_data, Busy, WriteReady, WordDone);
    end
    repeat (300) tick();
    checks++;
    if (doneT.size() != 0 || gotWords.size() != 0 || gotCtrl.size() != 0) begin
      errors++;
      $display("FAIL abort_nothing_done: done=%0d words=%0d ctrl=%0d, want 0 0 0", doneT.size(), gotWords.size(), gotCtrl.size());
    end
    checks++;
    if (riseCnt != 10 || fallCnt >= 16) begin
      errors++;
      $display("FAIL abort_edges: rises=%0d falls=%0d, want 10 and <16", riseCnt, fallCnt);
    end
    // Abort wins over an accept in the same cycle.
    WriteData = $urandom; WriteValid = 1'b1; Abort = 1'b1;
    tick();
    WriteValid = 1'b0; Abort = 1'b0;
    repeat (20) tick();
    checks++;
    if (Busy !== 1'b0 || riseCnt != 10 || WriteReady !== 1'b1) begin
      errors++;
      $display("FAIL abort_priority: busy=%b rises=%0d ready=%b, want 0 10 1", Busy, riseCnt, WriteReady);
    end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    flush();
    sendWord($urandom, 1'b0);
    while (riseCnt < 1 && t < 100) begin tick(); t++; end
    checks++;
    if (s_clk !== 1'b1) begin errors++; $display("FAIL rmid_setup: s_clk=%b want 1", s_clk); end
    reset = 1'b1;
    tick();
    checks++;
    if (s_clk !== 1'b0) begin errors++; $display("FAIL rmid_clk_drop: s_clk=%b want 0", s_clk); end
    repeat (2) begin
      tick();
      checks++;
      if (s_clk !== 1'b0 || s_data !== 1'b0 || Busy !== 1'b0 || WordDone !== 1'b0 || WriteReady !== 1'b1) begin
        errors++;
        $display("FAIL rmid_held: clk=%b data=%b busy=%b done=%b ready=%b, want 0 0 0 0 1", s_clk, s_data, Busy, WordDone, WriteReady);
      end
    end
    reset = 1'b0;
    tick();
    checks++;
    if (WriteReady !== 1'b1 || Busy !== 1'b0 || s_clk !== 1'b0) begin
      errors++;
      $display("FAIL rmid_release: ready=%b busy=%b clk=%b, want 1 0 0", WriteReady, Busy, s_clk);
    end
  endtask

  task automatic test_setup();
    logic [31:0] w, rec, ctl;
    logic hc[$], hd[$];
    int edges = 0, lastEdge = 0, badSetup = 0, badHigh = 0, badLow = 0, doneIdx = -1;
    w = $urandom; rec = 32'd0; ctl = 32'd0;
    WriteData4 = w; WriteValid4 = 1'b1;
    tick();
    WriteValid4 = 1'b0;
    for (int i = 0; i < 4 * 128 + 8; i++) begin
      tick();
      hc.push_back(sClk4);
      hd.push_back(sData4);
      if (WordDone4 === 1'b1) doneIdx = i;
    end
    for (int i = 1; i < hc.size(); i++) begin
      if (hc[i] !== hc[i-1]) begin
        for (int k = 1; k <= 4; k++) if (i - k >= 0 && hd[i-k] !== hd[i]) badSetup++;
        if (hc[i] === 1'b1) begin
          rec = {rec[30:0], hd[i]};
          if (edges > 0 && i - lastEdge != 8) badLow++;
        end else begin
          ctl = {ctl[30:0], hd[i]};
          if (i - lastEdge != 8) badHigh++;
        end
        edges++;
        lastEdge = i;
      end
    end
    checks++;
    if (edges != 64) begin errors++; $display("FAIL setup_edges: got %0d want 64", edges); end
    checks++;
    if (badSetup != 0) begin errors++; $display("FAIL setup_stable: %0d data changes near edges, want 0", badSetup); end
    checks++;
    if (badHigh != 0 || badLow != 0) begin
      errors++;
      $display("FAIL setup_widths: bad high=%0d bad low=%0d, want 0 0", badHigh, badLow);
    end
    checks++;
    if (rec !== w || ctl !== CTRL_EXP) begin
      errors++;
      $display("FAIL setup_content: data=%h ctrl=%h, want %h %h", rec, ctl, w, CTRL_EXP);
    end
    checks++;
    if (doneIdx != 511 || Busy4 !== 1'b0) begin
      errors++;
      $display("FAIL setup_duration: done at %0d busy=%b, want 511 0", doneIdx, Busy4);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_abort();
    test_setup();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
